// File: rtl/qtune_sequencer.sv
// qtune_sequencer: bisection search on the bias-current reference i_ref until
// the measured Q lands within TOL of the requested Q.
//
// Each iteration applies the midpoint of [lo, hi], waits SETTLE_CYC cycles for
// the analog path to settle, then requests one measurement and evaluates it.
//
// Handshake: meas_req is high for every cycle spent in MEASURE. A measurement
// is taken on the first cycle in which meas_req and meas_valid are both high.
// meas_req drops on the following cycle. meas_valid outside MEASURE has no
// effect.
//
// fsm_state exposes the controller state for debug and checker binding:
// 0 IDLE, 1 APPLY, 2 SETTLE, 3 MEASURE, 4 EVAL, 5 FINISH.
module qtune_sequencer #(
    parameter int WIDTH        = 10,
    parameter int TOL          = 30,
    parameter int SETTLE_CYC   = 16,
    parameter int MAX_ITER     = 12,
    parameter int MEAS_TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] desired_q,
    input  logic [WIDTH-1:0] i_ref_setup,
    input  logic [WIDTH-1:0] meas_q,
    input  logic             meas_valid,
    output logic             meas_req,
    output logic [WIDTH-1:0] i_ref,
    output logic             busy,
    output logic             done,
    output logic             converged,
    output logic             fail,
    output logic [7:0]       iter_count,
    output logic [2:0]       fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_APPLY   = 3'd1,
        S_SETTLE  = 3'd2,
        S_MEASURE = 3'd3,
        S_EVAL    = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    // One timer serves both the settle wait and the measurement timeout.
    localparam int TMAX = (SETTLE_CYC > MEAS_TIMEOUT) ? SETTLE_CYC : MEAS_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(MEAS_TIMEOUT - 1);
    localparam logic [WIDTH:0] TOL_W       = (WIDTH+1)'(TOL);

    state_t state, state_next;

    logic [WIDTH-1:0] lo, hi, target, meas_cap;
    logic [TW-1:0]    timer;

    // Evaluation datapath.
    logic signed [WIDTH:0] diff;
    logic        [WIDTH:0] err_mag;
    logic        [WIDTH:0] span;
    logic [WIDTH-1:0]      lo_n, hi_n, midpoint;
    logic                  within_tol, iter_limit, span_small;
    logic                  finish_ok, enter_finish;

    // Midpoint and error math, both carried one bit wider to avoid overflow.
    always_comb begin
        midpoint   = WIDTH'(({1'b0, lo} + {1'b0, hi}) >> 1);
        diff       = signed'({1'b0, meas_cap}) - signed'({1'b0, target});
        err_mag    = diff[WIDTH] ? unsigned'(-diff) : unsigned'(diff);
        within_tol = (err_mag <= TOL_W);
        lo_n       = lo;
        hi_n       = hi;
        if (meas_cap < target) begin
            lo_n = i_ref;
        end else if (meas_cap > target) begin
            hi_n = i_ref;
        end
        span       = {1'b0, hi_n} - {1'b0, lo_n};
        span_small = (span <= (WIDTH+1)'(1));
        iter_limit = ((iter_count + 8'd1) == 8'(MAX_ITER));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort pre-empts every busy state, including a converging EVAL.
    always_comb begin
        state_next = state;
        finish_ok  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_APPLY;
            end
            S_APPLY: begin
                state_next = abort ? S_FINISH : S_SETTLE;
            end
            S_SETTLE: begin
                if (abort)                     state_next = S_FINISH;
                else if (timer == SETTLE_LAST) state_next = S_MEASURE;
            end
            S_MEASURE: begin
                if (abort)                      state_next = S_FINISH;
                else if (meas_valid)            state_next = S_EVAL;
                else if (timer == TIMEOUT_LAST) state_next = S_FINISH;
            end
            S_EVAL: begin
                if (abort) begin
                    state_next = S_FINISH;
                end else if (within_tol) begin
                    state_next = S_FINISH;
                    finish_ok  = 1'b1;
                end else if (iter_limit || span_small) begin
                    state_next = S_FINISH;
                end else begin
                    state_next = S_APPLY;
                end
            end
            S_FINISH: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        enter_finish = (state_next == S_FINISH) && (state != S_FINISH);
    end

    // Output decode from the current state.
    always_comb begin
        busy      = (state == S_APPLY) || (state == S_SETTLE) ||
                    (state == S_MEASURE) || (state == S_EVAL);
        done      = (state == S_FINISH);
        meas_req  = (state == S_MEASURE);
        fsm_state = state;
    end

    // Search bounds, timer, captured measurement and sticky result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo         <= '0;
            hi         <= '0;
            target     <= '0;
            meas_cap   <= '0;
            timer      <= '0;
            i_ref      <= '0;
            iter_count <= '0;
            converged  <= 1'b0;
            fail       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lo         <= '0;
                        hi         <= i_ref_setup;
                        target     <= desired_q;
                        iter_count <= '0;
                        converged  <= 1'b0;
                        fail       <= 1'b0;
                    end
                end
                S_APPLY: begin
                    i_ref <= midpoint;
                    timer <= '0;
                end
                S_SETTLE: begin
                    timer <= (timer == SETTLE_LAST) ? '0 : timer + 1'b1;
                end
                S_MEASURE: begin
                    timer <= timer + 1'b1;
                    if (meas_valid) meas_cap <= meas_q;
                end
                S_EVAL: begin
                    iter_count <= iter_count + 8'd1;
                    lo         <= lo_n;
                    hi         <= hi_n;
                end
                default: begin
                end
            endcase
            // Any non-converged exit parks the bias at zero for safety.
            if (enter_finish) begin
                if (finish_ok) begin
                    converged <= 1'b1;
                end else begin
                    fail  <= 1'b1;
                    i_ref <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_qtune_sequencer.sv
// Directed bench for qtune_sequencer with a plant model meas_q = i_ref and
// a two-cycle measurement latency.
module tb_qtune_sequencer;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0, start2 = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] desired_q = '0, i_ref_setup = '0;
    logic         plant_en = 1'b1;

    logic [W-1:0] meas_q = '0, meas_q2 = '0;
    logic         meas_valid = 1'b0, meas_valid2 = 1'b0;
    logic         meas_req, meas_req2;
    logic [W-1:0] i_ref, i_ref2;
    logic         busy, busy2, done, done2, converged, converged2, fail, fail2;
    logic [7:0]   iter_count, iter_count2;
    logic [2:0]   fsm_state, fsm_state2;

    int total = 0;
    int passed = 0;
    logic [W-1:0] obs_q[$];

    always #5 clk = ~clk;

    qtune_sequencer #(.WIDTH(W), .TOL(30), .SETTLE_CYC(4), .MAX_ITER(12), .MEAS_TIMEOUT(1023)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .desired_q(desired_q), .i_ref_setup(i_ref_setup),
        .meas_q(meas_q), .meas_valid(meas_valid), .meas_req(meas_req),
        .i_ref(i_ref), .busy(busy), .done(done), .converged(converged),
        .fail(fail), .iter_count(iter_count), .fsm_state(fsm_state)
    );

    qtune_sequencer #(.WIDTH(W), .TOL(30), .SETTLE_CYC(4), .MAX_ITER(2), .MEAS_TIMEOUT(1023)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
        .desired_q(desired_q), .i_ref_setup(i_ref_setup),
        .meas_q(meas_q2), .meas_valid(meas_valid2), .meas_req(meas_req2),
        .i_ref(i_ref2), .busy(busy2), .done(done2), .converged(converged2),
        .fail(fail2), .iter_count(iter_count2), .fsm_state(fsm_state2)
    );

    // Plant for dut: answers a request two cycles after it appears.
    int lat = 0;
    always @(posedge clk) begin
        meas_valid <= 1'b0;
        if (plant_en && meas_req && !meas_valid) begin
            if (lat == 1) begin
                meas_valid <= 1'b1;
                meas_q     <= i_ref;
                lat        <= 0;
            end else begin
                lat <= lat + 1;
            end
        end else begin
            lat <= 0;
        end
    end

    // Plant for dut2.
    int lat2 = 0;
    always @(posedge clk) begin
        meas_valid2 <= 1'b0;
        if (meas_req2 && !meas_valid2) begin
            if (lat2 == 1) begin
                meas_valid2 <= 1'b1;
                meas_q2     <= i_ref2;
                lat2        <= 0;
            end else begin
                lat2 <= lat2 + 1;
            end
        end else begin
            lat2 <= 0;
        end
    end

    // Record each midpoint that actually gets measured on dut.
    always @(posedge clk) begin
        if (meas_req && meas_valid) obs_q.push_back(i_ref);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic pulse_start(input logic [W-1:0] dq, input logic [W-1:0] setup);
        desired_q   = dq;
        i_ref_setup = setup;
        obs_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done, 1);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int nobs, input int budget);
        int n = 0;
        while (!(fsm_state == st && obs_q.size() == nobs) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, (fsm_state == st && obs_q.size() == nobs), 1);
    endtask

    function automatic logic [W-1:0] obs_at(input int i);
        if (i < obs_q.size()) return obs_q[i];
        return '1;
    endfunction

    initial begin
        int n;
        int req_cycles;

        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_i_ref", i_ref, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {converged, fail, meas_req}, 0);
        chk("rst_iter", iter_count, 0);

        // Case 1: converge in four iterations, 9 cycles each.
        pulse_start(10'd600, 10'd1023);
        chk("c1_busy", busy, 1);
        wait_done("c1_done", 200, n);
        chk("c1_cycles", n, 36);
        chk("c1_conv", converged, 1);
        chk("c1_fail", fail, 0);
        chk("c1_iter", iter_count, 4);
        chk("c1_nobs", obs_q.size(), 4);
        chk("c1_mid0", obs_at(0), 511);
        chk("c1_mid1", obs_at(1), 767);
        chk("c1_mid2", obs_at(2), 639);
        chk("c1_mid3", obs_at(3), 575);
        chk("c1_busy_fin", busy, 0);
        @(negedge clk);
        chk("c1_done_pulse", done, 0);
        repeat (3) @(negedge clk);
        chk("c1_hold", i_ref, 575);
        chk("c1_conv_sticky", converged, 1);

        // Case 2: lo climbs to 99, then the span rule ends the run.
        pulse_start(10'd1023, 10'd100);
        wait_done("c2_done", 300, n);
        chk("c2_fail", fail, 1);
        chk("c2_conv", converged, 0);
        chk("c2_i_ref", i_ref, 0);
        chk("c2_iter", iter_count, 7);
        chk("c2_last_mid", obs_at(6), 99);
        @(negedge clk);

        // Upper bound of zero: converges when the target is within TOL of zero.
        pulse_start(10'd20, 10'd0);
        wait_done("z1_done", 100, n);
        chk("z1_conv", converged, 1);
        chk("z1_iter", iter_count, 1);
        chk("z1_i_ref", i_ref, 0);
        @(negedge clk);

        // Upper bound of zero with a distant target: span rule exit.
        pulse_start(10'd600, 10'd0);
        wait_done("z2_done", 100, n);
        chk("z2_fail", fail, 1);
        chk("z2_iter", iter_count, 1);
        @(negedge clk);

        // Case 3: iteration limit of two on dut2.
        desired_q   = 10'd600;
        i_ref_setup = 10'd1023;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("c3_done", done2, 1);
        chk("c3_fail", fail2, 1);
        chk("c3_conv", converged2, 0);
        chk("c3_iter", iter_count2, 2);
        chk("c3_i_ref", i_ref2, 0);
        @(negedge clk);

        // Case 4: no measurement ever arrives.
        plant_en = 1'b0;
        pulse_start(10'd600, 10'd1023);
        req_cycles = 0;
        n = 0;
        while (!done && n < 1200) begin
            @(negedge clk);
            if (meas_req) req_cycles++;
            n++;
        end
        chk("c4_done", done, 1);
        chk("c4_req_cycles", req_cycles, 1023);
        chk("c4_fail", fail, 1);
        chk("c4_req_low", meas_req, 0);
        chk("c4_i_ref", i_ref, 0);
        chk("c4_iter", iter_count, 0);
        plant_en = 1'b1;
        @(negedge clk);

        // Case 5: a second start while busy is ignored; abort in the settle of iteration 2.
        pulse_start(10'd600, 10'd1023);
        repeat (2) @(negedge clk);
        desired_q   = 10'd1023;
        i_ref_setup = 10'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_state("c5_reach", 3'd2, 1, 50);
        chk("c5_i_ref_iter2", i_ref, 767);
        chk("c5_mid0", obs_at(0), 511);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("c5_done", done, 1);
        chk("c5_fail", fail, 1);
        chk("c5_i_ref", i_ref, 0);
        chk("c5_req", meas_req, 0);
        chk("c5_busy", busy, 0);
        @(negedge clk);
        chk("c5_done_drop", done, 0);

        // Abort raised in the converging EVAL cycle wins over convergence.
        pulse_start(10'd600, 10'd1023);
        wait_state("ac_reach", 3'd4, 4, 100);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ac_done", done, 1);
        chk("ac_fail", fail, 1);
        chk("ac_conv", converged, 0);
        chk("ac_i_ref", i_ref, 0);
        @(negedge clk);

        // Case 6: reset mid-MEASURE, then a fresh run repeats case 1.
        pulse_start(10'd600, 10'd1023);
        wait_state("c6_reach", 3'd3, 1, 100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("c6_i_ref", i_ref, 0);
        chk("c6_outs", {busy, done, converged, fail, meas_req}, 0);
        chk("c6_iter", iter_count, 0);
        @(negedge clk);
        pulse_start(10'd600, 10'd1023);
        wait_done("c6_done", 200, n);
        chk("c6_cycles", n, 36);
        chk("c6_conv", converged, 1);
        chk("c6_iter2", iter_count, 4);
        chk("c6_mid3", obs_at(3), 575);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
